// File: rtl/hp_bar_animator.sv
// hp_bar_animator
//   Animates a displayed HP value per channel toward a loaded target, one
//   STEP per frame tick, and renders every channel's HP bar as a registered
//   pixel stream.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   frame_tick               one-cycle pulse per video frame
//   load_valid/ready/ch/hp   target load handshake (accepted only when idle)
//   anim_busy, anim_done     animation in progress / one-cycle completion pulse
//   disp_hp, hp_zero         displayed HP per channel (ch0 in LSBs), zero flags
//   bar_h_start, bar_v_start per-channel bar origin, 10 bits each, packed
//   h_cnt, v_cnt             current pixel position
//   pixel_hit, pixel_color   registered bar hit flag and RGB444 colour
module hp_bar_animator #(
    parameter int NUM_CH    = 2,
    parameter int HP_W      = 8,
    parameter int HP_MAX    = 200,
    parameter int STEP      = 1,
    parameter int BAR_SCALE = 1,
    parameter int BAR_H     = 10
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       frame_tick,
    input  logic                                       load_valid,
    output logic                                       load_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] load_ch,
    input  logic [HP_W-1:0]                            load_hp,
    output logic                                       anim_busy,
    output logic                                       anim_done,
    output logic [NUM_CH*HP_W-1:0]                     disp_hp,
    output logic [NUM_CH-1:0]                          hp_zero,
    input  logic [NUM_CH*10-1:0]                       bar_h_start,
    input  logic [NUM_CH*10-1:0]                       bar_v_start,
    input  logic [9:0]                                 h_cnt,
    input  logic [9:0]                                 v_cnt,
    output logic                                       pixel_hit,
    output logic [11:0]                                pixel_color
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [HP_W-1:0] HP_MAX_V = HP_W'(HP_MAX);
    localparam logic [HP_W:0]   STEP_V   = (HP_W+1)'(STEP);
    localparam logic [10:0]     BAR_LEN  = 11'(HP_MAX * BAR_SCALE);
    localparam logic [10:0]     BAR_HV   = 11'(BAR_H);
    localparam logic [10:0]     SCALE_V  = 11'(BAR_SCALE);
    // Colour thresholds compared against 4*disp
    localparam logic [HP_W+2:0] HALF_V   = (HP_W+3)'(2 * HP_MAX);
    localparam logic [HP_W+2:0] QUART_V  = (HP_W+3)'(HP_MAX);

    typedef enum logic [1:0] {IDLE, ANIM, DONE} state_t;

    state_t          state, state_n;
    logic [HP_W-1:0] disp     [NUM_CH];
    logic [HP_W-1:0] target   [NUM_CH];
    logic [HP_W-1:0] disp_n   [NUM_CH];
    logic [HP_W-1:0] target_n [NUM_CH];
    logic [HP_W:0]   move     [NUM_CH];
    logic [HP_W:0]   dec      [NUM_CH];
    logic [HP_W:0]   inc      [NUM_CH];
    logic [NUM_CH-1:0] above, below;
    logic            all_eq;
    logic            load_ok;
    logic [HP_W-1:0] load_clamped;

    logic [NUM_CH-1:0] on_track, filled;
    logic [11:0]       fill_color [NUM_CH];
    logic              hit_n;
    logic [11:0]       color_n;
    logic [10:0]       hh, vv;

    assign hh = {1'b0, h_cnt};
    assign vv = {1'b0, v_cnt};

    assign load_ok      = load_valid && ({1'b0, load_ch} < (CH_W+1)'(NUM_CH));
    assign load_clamped = (load_hp > HP_MAX_V) ? HP_MAX_V : load_hp;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [HP_W:0]   gap;
        logic [10:0]     hs, vs;
        logic [HP_W+2:0] quad;

        // Step toward target, limited to the remaining distance
        assign above[i] = disp[i] > target[i];
        assign below[i] = disp[i] < target[i];
        assign gap      = above[i] ? ({1'b0, disp[i]} - {1'b0, target[i]})
                                   : ({1'b0, target[i]} - {1'b0, disp[i]});
        assign move[i]  = (gap < STEP_V) ? gap : STEP_V;
        assign dec[i]   = {1'b0, disp[i]} - move[i];
        assign inc[i]   = {1'b0, disp[i]} + move[i];

        assign disp_hp[i*HP_W +: HP_W] = disp[i];
        assign hp_zero[i]              = (disp[i] == '0);

        // Geometry in 11 bits so origin + length cannot wrap past 1023
        assign hs          = {1'b0, bar_h_start[i*10 +: 10]};
        assign vs          = {1'b0, bar_v_start[i*10 +: 10]};
        assign on_track[i] = (hh >= hs) && (hh < hs + BAR_LEN) &&
                             (vv >= vs) && (vv < vs + BAR_HV);
        assign filled[i]   = hh < hs + 11'(disp[i]) * SCALE_V;
        assign quad        = {1'b0, disp[i], 2'b00};
        assign fill_color[i] = (quad > HALF_V)  ? 12'h0f0 :
                               (quad > QUART_V) ? 12'hff0 : 12'hf00;
    end

    always_comb begin
        all_eq = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (disp[i] != target[i]) all_eq = 1'b0;
        end
    end

    always_comb begin
        state_n    = state;
        load_ready = 1'b0;
        anim_busy  = 1'b0;
        anim_done  = 1'b0;
        disp_n     = disp;
        target_n   = target;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_ok) begin
                    target_n[load_ch] = load_clamped;
                    state_n           = ANIM;
                end
            end
            ANIM: begin
                anim_busy = 1'b1;
                if (all_eq) begin
                    state_n = DONE;
                end else if (frame_tick) begin
                    for (int unsigned i = 0; i < NUM_CH; i++) begin
                        if (above[i])      disp_n[i] = dec[i][HP_W-1:0];
                        else if (below[i]) disp_n[i] = inc[i][HP_W-1:0];
                    end
                end
            end
            DONE: begin
                anim_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Walk channels from highest to lowest so the lowest index wins overlaps
    always_comb begin
        hit_n   = 1'b0;
        color_n = 12'h000;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (on_track[NUM_CH-1-k]) begin
                hit_n   = 1'b1;
                color_n = filled[NUM_CH-1-k] ? fill_color[NUM_CH-1-k] : 12'h888;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                disp[i]   <= HP_MAX_V;
                target[i] <= HP_MAX_V;
            end
        end else begin
            state  <= state_n;
            disp   <= disp_n;
            target <= target_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_hit   <= 1'b0;
            pixel_color <= 12'h000;
        end else begin
            pixel_hit   <= hit_n;
            pixel_color <= color_n;
        end
    end

endmodule

// File: tb/tb_hp_bar_animator.sv
module tb_hp_bar_animator;
    localparam int NUM_CH = 2;
    localparam int HP_W   = 8;
    localparam int HP_MAX = 200;
    localparam int STEP   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick, load_valid, load_ready, load_ch;
    logic [7:0]  load_hp;
    logic        anim_busy, anim_done;
    logic [15:0] disp_hp;
    logic [1:0]  hp_zero;
    logic [19:0] bar_h_start, bar_v_start;
    logic [9:0]  h_cnt, v_cnt;
    logic        pixel_hit;
    logic [11:0] pixel_color;

    // second instance exercising a coarse step
    logic        s7_tick, s7_lv, s7_ready, s7_ch, s7_busy, s7_done, s7_hit;
    logic [7:0]  s7_hp;
    logic [15:0] s7_disp;
    logic [1:0]  s7_zero;
    logic [11:0] s7_color;

    always #5 clk = ~clk;

    hp_bar_animator #(.NUM_CH(NUM_CH), .HP_W(HP_W), .HP_MAX(HP_MAX), .STEP(STEP),
                      .BAR_SCALE(1), .BAR_H(10)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .load_valid(load_valid), .load_ready(load_ready), .load_ch(load_ch),
        .load_hp(load_hp), .anim_busy(anim_busy), .anim_done(anim_done),
        .disp_hp(disp_hp), .hp_zero(hp_zero), .bar_h_start(bar_h_start),
        .bar_v_start(bar_v_start), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .pixel_hit(pixel_hit), .pixel_color(pixel_color));

    hp_bar_animator #(.NUM_CH(2), .HP_W(8), .HP_MAX(200), .STEP(7),
                      .BAR_SCALE(1), .BAR_H(10)) dut7 (
        .clk(clk), .rst_n(rst_n), .frame_tick(s7_tick),
        .load_valid(s7_lv), .load_ready(s7_ready), .load_ch(s7_ch),
        .load_hp(s7_hp), .anim_busy(s7_busy), .anim_done(s7_done),
        .disp_hp(s7_disp), .hp_zero(s7_zero), .bar_h_start(20'd0),
        .bar_v_start(20'd0), .h_cnt(10'd0), .v_cnt(10'd0),
        .pixel_hit(s7_hit), .pixel_color(s7_color));

    int checks = 0;
    int errors = 0;

    int m_disp[2];
    int m_tgt[2];
    int m_hs[2];
    int m_vs[2];

    typedef struct {
        int h0, v0, h1, v1, h, v;
        logic        hit;
        logic [11:0] col;
    } pix_vec_t;

    typedef struct {
        int          hp;
        logic [11:0] col;
    } col_vec_t;

    pix_vec_t pv[15];
    col_vec_t cv[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dsp(input int c);
        return disp_hp[c*8 +: 8];
    endfunction

    function automatic logic [7:0] dsp7(input int c);
        return s7_disp[c*8 +: 8];
    endfunction

    task automatic set_bars(input int h0, input int v0, input int h1, input int v1);
        m_hs[0] = h0; m_vs[0] = v0; m_hs[1] = h1; m_vs[1] = v1;
        bar_h_start = {10'(h1), 10'(h0)};
        bar_v_start = {10'(v1), 10'(v0)};
    endtask

    // Expected {hit, colour} for a pixel from the bar rules, using model HP
    function automatic logic [12:0] pix_model(input int h, input int v);
        for (int c = 0; c < 2; c++) begin
            if (h >= m_hs[c] && h < m_hs[c] + HP_MAX && v >= m_vs[c] && v < m_vs[c] + 10) begin
                if (h < m_hs[c] + m_disp[c]) begin
                    if (4 * m_disp[c] > 2 * HP_MAX) return {1'b1, 12'h0f0};
                    if (4 * m_disp[c] > HP_MAX)     return {1'b1, 12'hff0};
                    return {1'b1, 12'hf00};
                end
                return {1'b1, 12'h888};
            end
        end
        return 13'h0;
    endfunction

    task automatic do_load(input int c, input int hp);
        load_valid = 1'b1; load_ch = 1'(c); load_hp = 8'(hp);
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic run_to_done(input string name);
        int n = 0;
        frame_tick = 1'b1;
        do begin
            cyc();
            n++;
        end while (anim_done !== 1'b1 && n < 400);
        frame_tick = 1'b0;
        chk(name, anim_done, 1);
        cyc();
    endtask

    initial begin
        pv[0]  = '{330, 300, 100, 600, 340, 305, 1'b1, 12'h0f0};
        pv[1]  = '{330, 300, 100, 600, 460, 305, 1'b1, 12'h888};
        pv[2]  = '{330, 300, 100, 600, 340, 310, 1'b0, 12'h000};
        pv[3]  = '{330, 300, 100, 600, 329, 305, 1'b0, 12'h000};
        pv[4]  = '{330, 300, 100, 600, 449, 305, 1'b1, 12'h0f0};
        pv[5]  = '{330, 300, 100, 600, 450, 305, 1'b1, 12'h888};
        pv[6]  = '{330, 300, 100, 600, 529, 309, 1'b1, 12'h888};
        pv[7]  = '{330, 300, 100, 600, 530, 305, 1'b0, 12'h000};
        pv[8]  = '{330, 300, 100, 600, 120, 605, 1'b1, 12'h0f0};
        pv[9]  = '{330, 300, 100, 600, 260, 605, 1'b1, 12'h888};
        pv[10] = '{330, 300, 100, 600, 300, 605, 1'b0, 12'h000};
        pv[11] = '{330, 300, 330, 300, 460, 305, 1'b1, 12'h888};
        pv[12] = '{330, 300, 330, 300, 340, 299, 1'b0, 12'h000};
        pv[13] = '{1000, 300, 100, 600, 5, 305, 1'b0, 12'h000};
        pv[14] = '{1000, 300, 100, 600, 1020, 305, 1'b1, 12'h0f0};

        cv[0] = '{40,  12'hf00};
        cv[1] = '{50,  12'hf00};
        cv[2] = '{51,  12'hff0};
        cv[3] = '{100, 12'hff0};
        cv[4] = '{101, 12'h0f0};
        cv[5] = '{0,   12'h888};

        rst_n = 1'b0; frame_tick = 1'b0; load_valid = 1'b0; load_ch = 1'b0; load_hp = '0;
        h_cnt = '0; v_cnt = '0;
        s7_tick = 1'b0; s7_lv = 1'b0; s7_ch = 1'b0; s7_hp = '0;
        set_bars(330, 300, 100, 600);
        cyc(); cyc();

        chk("rst_ready", load_ready, 1);
        chk("rst_busy", anim_busy, 0);
        chk("rst_done", anim_done, 0);
        chk("rst_disp", disp_hp, {8'd200, 8'd200});
        chk("rst_zero", hp_zero, 0);
        chk("rst_hit", pixel_hit, 0);
        chk("rst_color", pixel_color, 12'h000);
        rst_n = 1'b1;
        cyc();

        // coarse step: clamped to remaining distance, then healing with clamped target
        s7_lv = 1'b1; s7_ch = 1'b1; s7_hp = 8'd195;
        cyc();
        s7_lv = 1'b0; s7_tick = 1'b1;
        cyc();
        s7_tick = 1'b0;
        chk("s7_dmg_clamp", dsp7(1), 195);
        cyc();
        chk("s7_done1", s7_done, 1);
        cyc();
        s7_lv = 1'b1; s7_ch = 1'b1; s7_hp = 8'd250;
        cyc();
        s7_lv = 1'b0; s7_tick = 1'b1;
        cyc();
        s7_tick = 1'b0;
        chk("s7_heal_clamp", dsp7(1), 200);
        chk("s7_ch0_kept", dsp7(0), 200);
        cyc();
        chk("s7_done2", s7_done, 1);
        cyc();

        // damage by ten, one unit per tick
        do_load(0, 190);
        chk("ready_drop", load_ready, 0);
        chk("busy_up", anim_busy, 1);
        for (int k = 0; k < 10; k++) begin
            frame_tick = 1'b1;
            cyc();
            chk($sformatf("ramp_%0d", k), dsp(0), 199 - k);
            chk($sformatf("ramp_done_%0d", k), anim_done, 0);
        end
        frame_tick = 1'b0;
        cyc();
        chk("ramp_done_pulse", anim_done, 1);
        chk("ramp_done_busy", anim_busy, 0);
        cyc();
        chk("ramp_done_once", anim_done, 0);
        chk("ramp_idle", load_ready, 1);

        // zero-distance load
        do_load(0, 190);
        chk("zero_anim", anim_busy, 1);
        cyc();
        chk("zero_done", anim_done, 1);
        chk("zero_disp", dsp(0), 190);
        cyc();
        chk("zero_idle", load_ready, 1);

        // load during animation is dropped
        do_load(1, 100);
        chk("drop_ready", load_ready, 0);
        do_load(1, 50);
        run_to_done("drop_done");
        chk("drop_disp", dsp(1), 100);

        // tick coinciding with an idle load is ignored
        frame_tick = 1'b1;
        do_load(1, 150);
        frame_tick = 1'b0;
        chk("idle_tick", dsp(1), 100);
        run_to_done("heal_done");
        chk("heal_disp", dsp(1), 150);

        // pixel path table
        do_load(0, 120);
        run_to_done("px_setup");
        m_disp[0] = 120; m_disp[1] = 150;
        for (int i = 0; i < 15; i++) begin
            set_bars(pv[i].h0, pv[i].v0, pv[i].h1, pv[i].v1);
            h_cnt = 10'(pv[i].h); v_cnt = 10'(pv[i].v);
            cyc();
            chk($sformatf("px_hit_%0d", i), pixel_hit, pv[i].hit);
            chk($sformatf("px_col_%0d", i), pixel_color, pv[i].col);
        end

        // colour thresholds
        set_bars(330, 300, 100, 600);
        for (int i = 0; i < 6; i++) begin
            do_load(0, cv[i].hp);
            run_to_done($sformatf("col_done_%0d", i));
            h_cnt = 10'd340; v_cnt = 10'd305;
            cyc();
            chk($sformatf("col_%0d", cv[i].hp), pixel_color, cv[i].col);
        end
        chk("zero_flag", hp_zero, 2'b01);
        chk("zero_val", dsp(0), 0);

        // reset mid-animation
        do_load(0, 200);
        for (int k = 0; k < 5; k++) begin
            frame_tick = 1'b1;
            cyc();
        end
        frame_tick = 1'b0;
        chk("pre_rst_disp", dsp(0), 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_disp", disp_hp, {8'd200, 8'd200});
        chk("mid_rst_busy", anim_busy, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("mid_rst_done_%0d", k), anim_done, 0);
        end
        rst_n = 1'b1;
        cyc();
        chk("post_rst_done", anim_done, 0);
        chk("post_rst_ready", load_ready, 1);

        // randomized transactions against the reference model
        m_disp[0] = HP_MAX; m_disp[1] = HP_MAX;
        m_tgt[0]  = HP_MAX; m_tgt[1]  = HP_MAX;
        set_bars(330, 300, 100, 600);
        for (int t = 0; t < 30; t++) begin
            int c, hp, n;
            logic [12:0] ep;
            logic reached;
            c  = int'($urandom_range(0, 1));
            hp = int'($urandom_range(0, 255));
            load_valid = 1'b1; load_ch = 1'(c); load_hp = 8'(hp);
            frame_tick = 1'($urandom_range(0, 1));
            h_cnt = 10'($urandom_range(300, 560)); v_cnt = 10'($urandom_range(295, 315));
            ep = pix_model(int'(h_cnt), int'(v_cnt));
            cyc();
            load_valid = 1'b0;
            m_tgt[c] = (hp > HP_MAX) ? HP_MAX : hp;
            chk("rnd_load_busy", anim_busy, 1);
            chk("rnd_load_pix", {pixel_hit, pixel_color}, ep);
            chk("rnd_load_disp", disp_hp, {8'(m_disp[1]), 8'(m_disp[0])});
            n = 0;
            reached = 1'b0;
            while (!reached && n < 1000) begin
                frame_tick = 1'($urandom_range(0, 1));
                load_valid = 1'($urandom_range(0, 1));
                load_ch    = 1'($urandom_range(0, 1));
                load_hp    = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) begin
                    h_cnt = 10'($urandom_range(300, 560)); v_cnt = 10'($urandom_range(295, 315));
                end else begin
                    h_cnt = 10'($urandom_range(80, 320));  v_cnt = 10'($urandom_range(595, 615));
                end
                ep = pix_model(int'(h_cnt), int'(v_cnt));
                reached = (m_disp[0] == m_tgt[0]) && (m_disp[1] == m_tgt[1]);
                if (!reached && frame_tick) begin
                    for (int k = 0; k < 2; k++) begin
                        if (m_disp[k] > m_tgt[k])
                            m_disp[k] -= (m_disp[k] - m_tgt[k] < STEP) ? m_disp[k] - m_tgt[k] : STEP;
                        else if (m_disp[k] < m_tgt[k])
                            m_disp[k] += (m_tgt[k] - m_disp[k] < STEP) ? m_tgt[k] - m_disp[k] : STEP;
                    end
                end
                cyc();
                n++;
                chk("rnd_disp", disp_hp, {8'(m_disp[1]), 8'(m_disp[0])});
                chk("rnd_done", anim_done, reached);
                chk("rnd_pix", {pixel_hit, pixel_color}, ep);
            end
            if (!reached) chk("rnd_timeout", 0, 1);
            frame_tick = 1'b0; load_valid = 1'b0;
            cyc();
            chk("rnd_idle", load_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
